// File: rtl/modulo_transmisor_infrarojo.sv
// NEC-style infrared frame transmitter.
// Sends a 32-bit frame {~command, command, ~address, address}, LSB first, as
// pulse-distance code. Marks are modulated by a square-wave carrier.
// All outputs come straight from flops, so irOut cannot glitch.
module modulo_transmisor_infrarojo #(
   parameter int UNIT         = 28125,
   parameter int CARRIER_HALF = 658
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] address,
   input  logic [7:0] command,
   output logic       irOut,
   output logic       envelope,
   output logic       busy,
   output logic       done,
   output logic [7:0] framesSent
);

   localparam int CW  = (UNIT > 1) ? $clog2(UNIT) : 1;
   localparam int CCW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
   } state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cyc;
   logic [4:0]       r_units;
   logic [4:0]       w_dur;
   logic             w_unit_end;
   logic             w_frame_end;
   logic             w_mark_nxt;
   logic             w_enter;
   logic [31:0]      r_payload;
   logic [4:0]       r_idx;
   logic             r_car, w_car_nxt;
   logic [CCW-1:0]   r_car_cnt, w_car_cnt_nxt;
   logic             r_ir, r_env, r_busy, r_done;
   logic [7:0]       r_frames;

   // State duration in units and end-of-state detection
   always_comb begin
      w_dur = 5'd1;
      case (r_state)
         LEAD_MARK:  w_dur = 5'd16;
         LEAD_SPACE: w_dur = 5'd8;
         BIT_SPACE:  w_dur = r_payload[r_idx] ? 5'd3 : 5'd1;
         default:    w_dur = 5'd1;
      endcase
      w_unit_end  = (r_cyc == CW'(UNIT - 1)) && (r_units == w_dur - 5'd1);
      w_frame_end = (r_state == STOP_MARK) && w_unit_end;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       if (start)      w_next = LEAD_MARK;
         LEAD_MARK:  if (w_unit_end) w_next = LEAD_SPACE;
         LEAD_SPACE: if (w_unit_end) w_next = BIT_MARK;
         BIT_MARK:   if (w_unit_end) w_next = BIT_SPACE;
         BIT_SPACE:  if (w_unit_end) w_next = (r_idx == 5'd31) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  if (w_unit_end) w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
      w_enter    = (w_next != r_state);
      w_mark_nxt = (w_next == LEAD_MARK) || (w_next == BIT_MARK) || (w_next == STOP_MARK);
   end

   // Carrier: restarts high on mark entry, toggles every CARRIER_HALF cycles, low in spaces
   always_comb begin
      w_car_nxt     = 1'b0;
      w_car_cnt_nxt = '0;
      if (w_mark_nxt) begin
         if (w_enter) begin
            w_car_nxt = 1'b1;
         end else if (r_car_cnt == CCW'(CARRIER_HALF - 1)) begin
            w_car_nxt = ~r_car;
         end else begin
            w_car_nxt     = r_car;
            w_car_cnt_nxt = r_car_cnt + 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Timing counters, payload latch, bit index and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cyc     <= '0;
         r_units   <= '0;
         r_payload <= '0;
         r_idx     <= '0;
         r_car     <= 1'b0;
         r_car_cnt <= '0;
         r_ir      <= 1'b0;
         r_env     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_frames  <= '0;
      end else begin
         r_car     <= w_car_nxt;
         r_car_cnt <= w_car_cnt_nxt;
         r_ir      <= w_mark_nxt & w_car_nxt;
         r_env     <= w_mark_nxt;
         r_busy    <= (w_next != IDLE);
         r_done    <= w_frame_end;
         if (w_frame_end) r_frames <= r_frames + 8'd1;

         // Payload is only captured from IDLE, so a stray start mid-frame is harmless
         if (r_state == IDLE && start) begin
            r_payload <= {~command, command, ~address, address};
            r_idx     <= '0;
         end else if (r_state == BIT_SPACE && w_unit_end && r_idx != 5'd31) begin
            r_idx <= r_idx + 5'd1;
         end

         if (w_enter || r_state == IDLE) begin
            r_cyc   <= '0;
            r_units <= '0;
         end else if (r_cyc == CW'(UNIT - 1)) begin
            r_cyc   <= '0;
            r_units <= r_units + 5'd1;
         end else begin
            r_cyc <= r_cyc + 1'b1;
         end
      end
   end

   assign irOut      = r_ir;
   assign envelope   = r_env;
   assign busy       = r_busy;
   assign done       = r_done;
   assign framesSent = r_frames;

endmodule

// File: tb/tb_modulo_transmisor_infrarojo.sv
// Bench for the IR transmitter. Main DUT uses UNIT=4, CARRIER_HALF=1; a second
// instance with UNIT=1 covers the 256-frame back-to-back wrap run quickly.
module tb_modulo_transmisor_infrarojo;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic [7:0] addr, cmd;
   logic       ir, env, busy, done;
   logic [7:0] fs;

   logic       rst2, start2;
   logic [7:0] addr2, cmd2;
   logic       ir2, env2, busy2, done2;
   logic [7:0] fs2;

   modulo_transmisor_infrarojo #(.UNIT(4), .CARRIER_HALF(1)) u_dut (
      .clock(clk), .reset(rst), .start(start), .address(addr), .command(cmd),
      .irOut(ir), .envelope(env), .busy(busy), .done(done), .framesSent(fs));

   modulo_transmisor_infrarojo #(.UNIT(1), .CARRIER_HALF(1)) u_dut2 (
      .clock(clk), .reset(rst2), .start(start2), .address(addr2), .command(cmd2),
      .irOut(ir2), .envelope(env2), .busy(busy2), .done(done2), .framesSent(fs2));

   int n_cmp = 0;
   int n_bad = 0;
   bit fin2  = 1'b0;

   typedef struct {
      logic [31:0] payload;
      int          busy_len;
      logic [7:0]  frames;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s @%0t", name, $time);
   endtask

   // ---------------- monitor: envelope run-lengths, carrier, scoreboard pop ----------------
   int          run_len[$];
   logic        run_lvl[$];
   logic        cur_lvl;
   int          cur_len;
   int          bcnt;
   logic [31:0] dec;
   bit          shape_ok;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         run_len.delete();
         run_lvl.delete();
         cur_len = 0;
         bcnt    = 0;
      end else begin
         if (busy) begin
            bcnt++;
            if (cur_len == 0) begin
               cur_lvl = env;
               cur_len = 1;
            end else if (env == cur_lvl) begin
               cur_len++;
            end else begin
               run_len.push_back(cur_len);
               run_lvl.push_back(cur_lvl);
               cur_lvl = env;
               cur_len = 1;
            end
            if (env) chk("carrier_phase", ir, (cur_len % 2) == 1);
            else     chk("ir_in_space", ir, 0);
         end else begin
            chk("idle_outputs", {ir, env}, 0);
         end
         if (done) begin
            if (cur_len > 0) begin
               run_len.push_back(cur_len);
               run_lvl.push_back(cur_lvl);
            end
            if (sbq.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               e        = sbq.pop_front();
               dec      = '0;
               shape_ok = (run_len.size() == 67);
               if (shape_ok) begin
                  if (run_len[0] != 64 || run_len[1] != 32 || run_len[66] != 4) shape_ok = 1'b0;
                  for (int i = 0; i < 67; i++)
                     if (run_lvl[i] != ((i % 2) == 0)) shape_ok = 1'b0;
                  for (int b = 0; b < 32; b++) begin
                     if (run_len[2 + 2*b] != 4) shape_ok = 1'b0;
                     if (run_len[3 + 2*b] == 12)     dec[b] = 1'b1;
                     else if (run_len[3 + 2*b] != 4) shape_ok = 1'b0;
                  end
               end
               chk("frame_shape", shape_ok, 1);
               chk("payload", dec, e.payload);
               chk("busy_len", bcnt, e.busy_len);
               chk("frames_sent", fs, e.frames);
            end
            run_len.delete();
            run_lvl.delete();
            cur_len = 0;
            bcnt    = 0;
         end
      end
   end

   // ---------------- stimulus for the main instance ----------------
   task automatic pulse_start(input logic [7:0] a, input logic [7:0] c);
      @(negedge clk);
      addr  = a;
      cmd   = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_empty(input int lim);
      int t = 0;
      while (sbq.size() != 0 && t < lim) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) begin
         fail_now("timeout_waiting_done");
         sbq.delete();
      end
   endtask

   initial begin
      int t;
      rst   = 1'b1;
      start = 1'b0;
      addr  = 8'h00;
      cmd   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irOut", ir, 0);
      chk("rst_envelope", env, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_framesSent", fs, 0);
      @(negedge clk);
      rst = 1'b0;

      // abort a frame with reset at cycle 100
      pulse_start(8'h00, 8'h00);
      repeat (98) @(posedge clk);
      #2;
      chk("busy_before_abort", busy, 1);
      rst = 1'b1;
      #1;
      chk("abort_irOut", ir, 0);
      chk("abort_envelope", env, 0);
      chk("abort_busy", busy, 0);
      chk("abort_framesSent", fs, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (600) @(negedge clk);
      chk("after_abort_framesSent", fs, 0);

      // first frame after release: 0x00/0x00
      sbq.push_back('{32'hFF00FF00, 484, 8'd1});
      pulse_start(8'h00, 8'h00);
      wait_empty(800);
      repeat (5) @(negedge clk);

      // 0xA5/0x3C with a stray start mid-frame
      sbq.push_back('{32'hC33C5AA5, 484, 8'd2});
      pulse_start(8'hA5, 8'h3C);
      repeat (200) @(negedge clk);
      addr  = 8'h12;
      cmd   = 8'h34;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_empty(800);
      repeat (20) @(negedge clk);

      // back-to-back: start held through the done cycle
      sbq.push_back('{32'h00FFFE01, 484, 8'd3});
      sbq.push_back('{32'h00FFFE01, 484, 8'd4});
      @(negedge clk);
      addr  = 8'h01;
      cmd   = 8'hFF;
      start = 1'b1;
      t = 0;
      while (sbq.size() > 1 && t < 800) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      start = 1'b0;
      chk("b2b_restart_busy", busy, 1);
      wait_empty(800);
      repeat (10) @(negedge clk);

      t = 0;
      while (!fin2 && t < 40000) begin
         @(negedge clk);
         t++;
      end
      if (!fin2) fail_now("timeout_wrap_run");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // ---------------- second instance: 256 frames with start held high ----------------
   initial begin
      int nd, t, gaps;
      rst2   = 1'b1;
      start2 = 1'b0;
      addr2  = 8'h5A;
      cmd2   = 8'hC3;
      nd     = 0;
      t      = 0;
      gaps   = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst2   = 1'b0;
      start2 = 1'b1;
      while (nd < 256 && t < 35000) begin
         @(negedge clk);
         t++;
         if (done2) begin
            nd++;
            chk("wrap_framesSent", fs2, nd % 256);
         end else if (!busy2) begin
            gaps++;
         end
      end
      start2 = 1'b0;
      chk("wrap_done_count", nd, 256);
      chk("wrap_final_zero", fs2, 0);
      chk("wrap_idle_gaps", gaps, 0);
      chk("wrap_total_cycles", t, 31232);
      fin2 = 1'b1;
   end

endmodule

// File: doc/modulo_transmisor_infrarojo.md
MODULO_TRANSMISOR_INFRAROJO -- requirements
Module: modulo_transmisor_infrarojo

Interface
REQ-001 SHALL have parameter UNIT, default 28125, giving the clock cycles per 562.5 us protocol unit at 50 MHz.
REQ-002 SHALL have parameter CARRIER_HALF, default 658, giving the clock cycles per carrier half-period (about 38 kHz).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to transmit one frame.
REQ-006 SHALL have port address, input, 8 bits: frame address byte.
REQ-007 SHALL have port command, input, 8 bits: frame command byte.
REQ-008 SHALL have port irOut, output, 1 bit: modulated drive to the IR LED.
REQ-009 SHALL have port envelope, output, 1 bit: unmodulated mark/space envelope, 1 = mark.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-012 SHALL have port framesSent, output, 8 bits: count of completed frames.

Function
REQ-013 SHALL implement these states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
REQ-014 In IDLE with start=1, SHALL latch the 32-bit payload {~command, command, ~address, address}, enter LEAD_MARK, and set busy=1 on that same edge.
REQ-015 SHALL ignore start while busy=1; the payload latch SHALL NOT change mid-frame.
REQ-016 State durations: LEAD_MARK 16 units, LEAD_SPACE 8 units, BIT_MARK 1 unit, STOP_MARK 1 unit.
REQ-017 BIT_SPACE duration: 1 unit for a 0 bit, 3 units for a 1 bit.
REQ-018 SHALL transmit payload bits LSB first (address bit0 first, ~command bit7 last) using a 5-bit bit index.
REQ-019 After BIT_SPACE of bit 31, SHALL enter STOP_MARK; otherwise SHALL enter BIT_MARK with the index incremented.
REQ-020 envelope SHALL be 1 exactly in the LEAD_MARK, BIT_MARK and STOP_MARK states.
REQ-021 The unit-cycle counter and unit counter SHALL clear on every state entry.
REQ-022 On each mark-state entry, the carrier SHALL restart at phase high; it SHALL toggle every CARRIER_HALF cycles while in a mark.
REQ-023 The carrier SHALL be held low outside marks.
REQ-024 irOut SHALL equal envelope AND carrier, registered with no glitches.
REQ-025 At the end of STOP_MARK, SHALL return to IDLE, set busy=0, pulse done=1 for one cycle, and increment framesSent.
REQ-026 framesSent SHALL wrap from 255 to 0.
REQ-027 If start=1 in the cycle done=1, a new frame SHALL be accepted, giving back-to-back frames.
REQ-028 Total busy time SHALL be (24 + 1 + 2*zeros + 4*ones) * UNIT cycles.

Reset
REQ-029 On reset=1, outputs SHALL clear immediately (asynchronous): irOut=0, envelope=0, busy=0, done=0, framesSent=0; state SHALL go to IDLE and all counters to 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse and no framesSent increment; the first start after release SHALL be accepted normally.

Verification (UNIT=4, CARRIER_HALF=1)
REQ-031 address=0x00, command=0x00, start pulsed 1 cycle -> busy high for exactly 484 cycles; envelope high for the first 64 cycles, then low for 32; done pulses once; framesSent=1.
REQ-032 address=0xA5, command=0x3C -> decoded mark/space widths give payload 0xC33C5AA5, LSB first; final STOP_MARK is 4 cycles.
REQ-033 During any mark, irOut toggles every cycle starting high; irOut=0 whenever envelope=0.
REQ-034 start held high continuously -> frames back-to-back with no idle gap; after 256 frames framesSent=0.
REQ-035 reset asserted at cycle 100 of a frame -> irOut, envelope and busy go to 0 in the same cycle, no done pulse, framesSent unchanged at 0.
REQ-036 start pulsed while busy -> no effect on the waveform; exactly one done pulse.
